stream_fifo_flushable: RTL and testbench

- Parameterised-depth valid/ready stream FIFO with synchronous flush.
- Sits at the consumer end of axi4_adapter channels (R data, B response) and absorbs bursts when the downstream core stalls.
- Optional fall-through mode gives zero-latency bypass when the FIFO is empty.
- Flush semantics match the adapter's existing flushable channel buffers, so a single flush_i can clear all stages of a channel.

---
 rtl/stream_fifo_flushable.sv | 110 +++++++++++
 tb/tb_stream_fifo_flushable.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_flushable.sv
// Valid/ready stream FIFO with synchronous flush and optional fall-through bypass.
// Status outputs (usage/full/empty) reflect stored entries only.
module stream_fifo_flushable #(
    parameter type         T            = logic,
    parameter int          DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0,
    localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  T               data_i,
    output logic           valid_o,
    input  logic           ready_i,
    output T               data_o,
    output logic [AddrW:0] usage_o,
    output logic           full_o,
    output logic           empty_o
);

    if (DEPTH < 1) begin : g_depth_check
        $error("stream_fifo_flushable: DEPTH must be >= 1");
    end

    localparam logic [AddrW:0]   DepthCnt = (AddrW + 1)'(DEPTH);
    localparam logic [AddrW-1:0] LastPtr  = AddrW'(DEPTH - 1);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;

    logic push, pop, bypass, do_write, do_read;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign usage_o = count_q;

    assign ready_o = !full_o && !flush_i;
    assign valid_o = (FALL_THROUGH ? (!empty_o || valid_i) : !empty_o) && !flush_i;

    always_comb begin
        data_o = mem_q[rd_ptr_q];
        if (FALL_THROUGH && empty_o) begin
            data_o = data_i;
        end
    end

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // A beat that enters and leaves an empty FIFO in one cycle never touches storage.
    assign bypass   = FALL_THROUGH && empty_o && push && pop;
    assign do_write = push && !bypass;
    assign do_read  = pop && !bypass;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DepthCnt);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full_o));
    a_no_pop_invalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && !valid_o));
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=> (flush_i || (valid_o && $stable(data_o))));
`endif

endmodule

// File: tb/tb_stream_fifo_flushable.sv
// Drives three FIFO configurations with shared stimulus and compares each
// against a queue-based reference model every cycle.
module tb_stream_fifo_flushable;

    localparam int N = 3;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [7:0] data_i  = '0;

    logic [N-1:0] rdy, vld, full, empty;
    logic [7:0]   dout  [N];
    logic [2:0]   usage [N];

    int unsigned depth_c [N] = '{4, 3, 4};
    bit          ft_c    [N] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  mq      [N][$];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    stream_fifo_flushable #(.T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b0)) u_d4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(rdy[0]), .data_i(data_i),
        .valid_o(vld[0]), .ready_i(ready_i), .data_o(dout[0]),
        .usage_o(usage[0]), .full_o(full[0]), .empty_o(empty[0]));

    stream_fifo_flushable #(.T(logic [7:0]), .DEPTH(3), .FALL_THROUGH(1'b0)) u_d3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(rdy[1]), .data_i(data_i),
        .valid_o(vld[1]), .ready_i(ready_i), .data_o(dout[1]),
        .usage_o(usage[1]), .full_o(full[1]), .empty_o(empty[1]));

    stream_fifo_flushable #(.T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b1)) u_ft (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(rdy[2]), .data_i(data_i),
        .valid_o(vld[2]), .ready_i(ready_i), .data_o(dout[2]),
        .usage_o(usage[2]), .full_o(full[2]), .empty_o(empty[2]));

    task automatic check_eq(input string tag, input int idx,
                            input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", tag, idx, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            int sz;
            bit e_vld;
            sz    = mq[i].size();
            e_vld = ((sz > 0) || (ft_c[i] && valid_i)) && !flush_i;
            check_eq("ready", i, 32'(rdy[i]), 32'((sz != int'(depth_c[i])) && !flush_i));
            check_eq("valid", i, 32'(vld[i]), 32'(e_vld));
            check_eq("usage", i, 32'(usage[i]), 32'(sz));
            check_eq("full",  i, 32'(full[i]), 32'(sz == int'(depth_c[i])));
            check_eq("empty", i, 32'(empty[i]), 32'(sz == 0));
            if (e_vld) begin
                check_eq("data", i, 32'(dout[i]), 32'((sz > 0) ? mq[i][0] : data_i));
            end
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            int sz;
            bit e_rdy, e_vld, push, pop, bypass;
            sz     = mq[i].size();
            e_rdy  = (sz != int'(depth_c[i])) && !flush_i;
            e_vld  = ((sz > 0) || (ft_c[i] && valid_i)) && !flush_i;
            push   = valid_i && e_rdy;
            pop    = e_vld && ready_i;
            bypass = 1'b0;
            if (flush_i) begin
                mq[i].delete();
            end else begin
                if (pop) begin
                    if (sz > 0) void'(mq[i].pop_front());
                    else        bypass = 1'b1;
                end
                if (push && !bypass) mq[i].push_back(data_i);
            end
        end
    endtask

    // Called shortly after a rising edge: apply inputs, check mid-cycle, then clock.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        #2;
        check_all();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic check_reset_values();
        check_all();
        for (int i = 0; i < N; i++) begin
            check_eq("rst_data", i, 32'(dout[i]), 32'h0);
        end
    endtask

    initial begin
        // Power-on reset
        #12;
        check_reset_values();
        #11;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill with downstream stalled, then drain
        for (int k = 0; k < 4; k++) step(1'b1, 8'hA1 + 8'(k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Wrap-around stream with toggling ready
        for (int k = 0; k < 14; k++) step(k < 10, 8'(k), (k % 2) == 0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push/pop at usage 2
        step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 8'h22 + 8'(k), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fall-through bypass from empty
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h5C, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with three stored beats, then no stale data
        for (int k = 0; k < 3; k++) step(1'b1, 8'h30 + 8'(k), 1'b0, 1'b0);
        step(1'b1, 8'h3F, 1'b1, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Multi-cycle flush
        step(1'b1, 8'h40, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 8'h41, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-burst
        step(1'b1, 8'h50, 1'b0, 1'b0);
        step(1'b1, 8'h51, 1'b0, 1'b0);
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        rst_ni  = 1'b0;
        for (int i = 0; i < N; i++) mq[i].delete();
        #1;
        check_reset_values();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step(1'b1, 8'h60, 1'b0, 1'b0);
        step(1'b1, 8'h61, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
